seq_divide: RTL and testbench

- Multi-cycle signed integer divider, parametrised in operand width. It computes quotient and remainder using one restoring-division step per clock.
- Registered start/done handshake, with error flags for divide-by-zero and signed overflow.
- Sits behind the BreadBoard ALU opcode decode and serves both the div (3) and mod (4) opcodes from one instance.

---
 rtl/seq_divide.sv | 198 +++++++++++++++++++
 tb/tb_seq_divide.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_divide.sv
// ---------------------------------------------------------------------------
// seq_divide -- multi-cycle signed integer divider (restoring, 1 step/clock)
//
// Computes quotient (truncated toward zero) and remainder (sign follows the
// dividend) of two WIDTH-bit two's-complement operands. One restoring step is
// performed per clock; divide-by-zero and MIN/-1 overflow short-circuit
// straight to the completion state.
//
// Parameters:
//   WIDTH      operand / quotient / remainder width in bits (4..32)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   signed_op  (only with SEQ_DIVIDE_UNSIGNED_SEL_EN) 1 = signed, 0 = unsigned
//   dividend   two's-complement dividend, captured on an accepted start
//   divisor    two's-complement divisor, captured on an accepted start
//   busy       high from the cycle after an accepted start until done
//   done       single-cycle pulse, results valid from this cycle
//   quotient   signed quotient
//   remainder  signed remainder
//   error      [0] divide-by-zero, [1] signed overflow; valid with done
//
// Optional feature macro: SEQ_DIVIDE_UNSIGNED_SEL_EN adds the signed_op input.
//
// Handshake: start is accepted on a rising edge only when the FSM is IDLE;
// a start seen in any other state is dropped and the operands are not
// re-captured. done pulses for exactly one cycle per accepted start (none
// when reset aborts an operation), and quotient/remainder/error are stable
// from that cycle until the next operation completes.
// ---------------------------------------------------------------------------
module seq_divide #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SEQ_DIVIDE_UNSIGNED_SEL_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t state, state_nxt;

  // Signedness of the request being presented on the ports.
  logic is_signed;
`ifdef SEQ_DIVIDE_UNSIGNED_SEL_EN
  assign is_signed = signed_op;
`else
  assign is_signed = 1'b1;
`endif

  logic accept;
  logic div_zero;
  logic ovf;
  assign accept   = (state == IDLE) && start;
  assign div_zero = (divisor == '0);
  assign ovf      = is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES);

  // Magnitudes are formed in WIDTH+1 bits so |MIN| = 2^(WIDTH-1) is exact.
  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   dvd_ext, dvs_ext, dvd_mag, dvs_mag;
  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_ext = {dvd_neg, dividend};
  assign dvs_ext = {dvs_neg, divisor};
  assign dvd_mag = dvd_neg ? (~dvd_ext + 1'b1) : dvd_ext;
  assign dvs_mag = dvs_neg ? (~dvs_ext + 1'b1) : dvs_ext;

  // Working registers.
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then trial-subtract. The extra top bit of trial is the
  // borrow, so a set MSB means "restore".
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  assign shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {1'b0, dvs_q};
  assign trial_ok = ~trial[WIDTH+1];

  // Sign fix-up of the magnitude results.
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign quo_fix = sign_q_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = sign_r_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (div_zero || ovf) ? FIN : RUN;
      RUN:  if (cnt_q == LAST_STEP) state_nxt = FIX;
      FIX:  state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flops decoded from the next state, so they track the
  // state register exactly while coming straight out of a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN) || (state_nxt == FIX);
      done <= (state_nxt == FIN);
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      error     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_q    <= '0;
            quo_q    <= dvd_mag[WIDTH-1:0];
            dvs_q    <= dvs_mag;
            cnt_q    <= '0;
            sign_q_q <= dvd_neg ^ dvs_neg;
            sign_r_q <= dvd_neg;
            error    <= {ovf, div_zero};
            // Error paths finish next cycle, so their results are loaded now.
            if (div_zero) begin
              quotient  <= '0;
              remainder <= dividend;
            end else if (ovf) begin
              quotient  <= MIN_VAL;
              remainder <= '0;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (trial_ok) begin
            rem_q <= trial[WIDTH:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted;
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient  <= quo_fix;
          remainder <= rem_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divide.sv
// ---------------------------------------------------------------------------
// tb_seq_divide -- directed bench for seq_divide (WIDTH=16).
// Driver tasks issue operations and push the hand-computed result into a
// scoreboard queue; a monitor pops and compares on every done pulse. The
// driver also checks busy/done timing relative to the start-sampling edge.
// ---------------------------------------------------------------------------
module tb_seq_divide;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   error;

  seq_divide #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .error     (error)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected entry: {quotient, remainder, error}.
  logic [2*W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: actual=done with no pending result required=no done (t=%0t)", $time);
      end else begin
        logic [2*W+1:0] e;
        e = exp_q.pop_front();
        check("quotient", 32'(quotient), 32'(e[2*W+1:W+2]));
        check("remainder", 32'(remainder), 32'(e[W+1:2]));
        check("error", 32'(error), 32'(e[1:0]));
      end
    end
  end

  // Issue one operation; inj_cyc>0 pulses a stray 5/5 start at that cycle.
  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input logic [1:0] ee, input int lat, input int inj_cyc);
    int cyc;
    bit got;
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    exp_q.push_back({W'(eq), W'(er), ee});
    @(posedge clk);  // start-sampling edge
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    got = 0;
    while (cyc <= 40 && !got) begin
      if (inj_cyc > 0 && cyc == inj_cyc + 1) start = 1'b0;
      if (done === 1'b1) begin
        got = 1;
      end else begin
        check($sformatf("busy_cyc%0d", cyc), 32'(busy), 32'd1);
        if (inj_cyc > 0 && cyc == inj_cyc) begin
          start    = 1'b1;
          dividend = W'(5);
          divisor  = W'(5);
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("done_latency", got ? 32'(cyc) : 32'hffff_ffff, 32'(lat));
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  // Start an operation and abort it with reset at cycle rst_cyc.
  task automatic abort_op(input int a, input int b, input int rst_cyc);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < rst_cyc; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);  // any done here would be flagged by the monitor
    check("post_rst_quotient", 32'(quotient), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32000, 16000, 2, 0, 2'b00, 18, 0);
    run_op(-7, 2, -3, -1, 2'b00, 18, 0);
    run_op(7, -2, -3, 1, 2'b00, 18, 0);
    run_op(-7, -2, 3, -1, 2'b00, 18, 0);
    run_op(11, 0, 0, 11, 2'b01, 1, 0);
    run_op(11, 15, 0, 11, 2'b00, 18, 0);
    run_op(-32768, -1, -32768, 0, 2'b10, 1, 0);
    run_op(-32768, 1, -32768, 0, 2'b00, 18, 0);
    run_op(32767, -32768, 0, 32767, 2'b00, 18, 0);
    run_op(-32768, 7, -4681, -1, 2'b00, 18, 0);
    run_op(12345, -100, -123, 45, 2'b00, 18, 0);
    run_op(100, 7, 14, 2, 2'b00, 18, 4);

    abort_op(1000, 3, 9);
    run_op(9, 3, 3, 0, 2'b00, 18, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout: actual=time limit reached required=test complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
